// File: rtl/kgp_ctrl_pkg.sv
// Shared definitions for the KGP mini-RISC multi-cycle control unit:
// opcode constants, ALU / branch operation encodings, instruction classes,
// FSM state encoding and the register-write / write-back mux selects.
package kgp_ctrl_pkg;

   localparam logic [5:0] OP_ALU   = 6'd0;
   localparam logic [5:0] OP_ALUI  = 6'd1;
   localparam logic [5:0] OP_LW    = 6'd3;
   localparam logic [5:0] OP_SW    = 6'd4;
   localparam logic [5:0] OP_BR    = 6'd5;
   localparam logic [5:0] OP_BRREG = 6'd6;
   localparam logic [5:0] OP_HALT  = 6'h3F;

   // The ALU function field selects the ALU operation directly; any func
   // value at or above ALU_FUNC_COUNT is an unknown ALU function.
   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOT,
      ALU_SLA,
      ALU_SRA,
      ALU_SRL
   } alu_op_t;

   localparam logic [5:0] ALU_FUNC_COUNT = 6'd9;

   typedef enum logic [4:0] {
      BR_NONE = 5'd0,
      BR_B    = 5'd1,
      BR_BL   = 5'd2,
      BR_BCY  = 5'd3,
      BR_BNCY = 5'd4,
      BR_BR   = 5'd5,
      BR_BLTZ = 5'd6,
      BR_BZ   = 5'd7,
      BR_BNZ  = 5'd8
   } br_op_t;

   typedef enum logic [2:0] {
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_HALT
   } instr_class_t;

   // S_TRAP is only reachable when illegal-instruction trapping is built in.
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_TRAP
   } state_t;

   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_RS   = 2'b01;
   localparam logic [1:0] RW_LINK = 2'b10;

   localparam logic [1:0] WB_SEL_PC  = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_ALU = 2'd2;

   function automatic logic is_alu_func(input logic [5:0] func);
      return func < ALU_FUNC_COUNT;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_ctrl_decoder.sv
// Combinational instruction decoder: turns an (opcode, func) pair into the
// static control word for that instruction, its class and an illegal flag.
// An illegal encoding yields an all-zero control word.
module ctrl_decoder
   import kgp_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func,
   output logic [3:0] alu_op,
   output logic       alu_mux_ctrl,
   output logic       imm_mux_ctrl,
   output logic [1:0] wb_sel,
   output logic [4:0] br_op,
   output logic       link,
   output logic [2:0] instr_class,
   output logic       illegal
);

   // Map the opcode class to ALU, immediate, write-back and branch selects.
   always_comb begin
      alu_op       = ALU_ADD;
      alu_mux_ctrl = 1'b0;
      imm_mux_ctrl = 1'b0;
      wb_sel       = WB_SEL_PC;
      br_op        = BR_NONE;
      link         = 1'b0;
      instr_class  = CLS_ALU;
      illegal      = 1'b0;
      case (opcode)
         OP_ALU, OP_ALUI: begin
            if (is_alu_func(func)) begin
               alu_op       = func[3:0];
               alu_mux_ctrl = (opcode == OP_ALUI);
               wb_sel       = WB_SEL_ALU;
            end else begin
               illegal = 1'b1;
            end
         end
         OP_LW: begin
            instr_class  = CLS_LOAD;
            alu_mux_ctrl = 1'b1;
            imm_mux_ctrl = 1'b1;
            wb_sel       = WB_SEL_MEM;
         end
         OP_SW: begin
            instr_class  = CLS_STORE;
            alu_mux_ctrl = 1'b1;
            imm_mux_ctrl = 1'b1;
         end
         OP_BR, OP_BRREG: begin
            if (func[5:2] == 4'd0) begin
               instr_class = CLS_BRANCH;
               if (opcode == OP_BR) begin
                  br_op = 5'(BR_B) + {3'b000, func[1:0]};
                  link  = (func[1:0] == 2'b01);
               end else begin
                  br_op = 5'(BR_BR) + {3'b000, func[1:0]};
               end
            end else begin
               illegal = 1'b1;
            end
         end
         OP_HALT: begin
            instr_class = CLS_HALT;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the KGP mini-RISC. Sequences
// FETCH/DECODE/EXEC/MEM/WB, drives every data_path control input, handles the
// run/halt handshake and counts retired instructions (saturating).
// Build option: define CTRL_ILLEGAL_TRAP_EN to send unknown encodings to a
// sticky TRAP state; otherwise they retire as a NOP.
module multicycle_control_unit
   import kgp_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   output logic [1:0]       reg_write,
   output logic             imm_mux_ctrl,
   output logic             alu_mux_ctrl,
   output logic [3:0]       alu_op,
   output logic             dmem_enable,
   output logic             dmem_write_enable,
   output logic [1:0]       reg_write_mux_ctrl,
   output logic [4:0]       br_op,
   output logic             pc_write,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   state_t     next_state;
   logic [5:0] ir_opcode;
   logic [5:0] ir_func;
   logic [5:0] dec_opcode;
   logic [5:0] dec_func;
   logic [3:0] dec_alu_op;
   logic       dec_alu_mux;
   logic       dec_imm_mux;
   logic [1:0] dec_wb_sel;
   logic [4:0] dec_br_op;
   logic       dec_link;
   logic [2:0] dec_class;
   logic       dec_illegal;

   // In DECODE the live inputs choose the next state; afterwards only the IR is used.
   always_comb begin
      dec_opcode = ir_opcode;
      dec_func   = ir_func;
      if (state == S_DECODE) begin
         dec_opcode = opcode;
         dec_func   = func;
      end
   end

   ctrl_decoder u_decoder (
      .opcode       (dec_opcode),
      .func         (dec_func),
      .alu_op       (dec_alu_op),
      .alu_mux_ctrl (dec_alu_mux),
      .imm_mux_ctrl (dec_imm_mux),
      .wb_sel       (dec_wb_sel),
      .br_op        (dec_br_op),
      .link         (dec_link),
      .instr_class  (dec_class),
      .illegal      (dec_illegal)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   // Instruction register, captured while the instruction is being decoded.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ir_opcode <= '0;
         ir_func   <= '0;
      end else if (state == S_DECODE) begin
         ir_opcode <= opcode;
         ir_func   <= func;
      end
   end

   // Next-state logic and per-state control outputs.
   always_comb begin
      next_state         = state;
      reg_write          = RW_NONE;
      imm_mux_ctrl       = 1'b0;
      alu_mux_ctrl       = 1'b0;
      alu_op             = ALU_ADD;
      dmem_enable        = 1'b0;
      dmem_write_enable  = 1'b0;
      reg_write_mux_ctrl = WB_SEL_PC;
      br_op              = BR_NONE;
      pc_write           = 1'b0;
      busy               = !(state == S_IDLE || state == S_HALT);
      halted             = (state == S_HALT || state == S_TRAP);

      if (state == S_EXEC || state == S_MEM || state == S_WB) begin
         alu_op             = dec_alu_op;
         alu_mux_ctrl       = dec_alu_mux;
         imm_mux_ctrl       = dec_imm_mux;
         reg_write_mux_ctrl = dec_wb_sel;
      end

      case (state)
         S_IDLE: begin
            if (run) next_state = S_FETCH;
         end
         S_FETCH: begin
            next_state = S_DECODE;
         end
         S_DECODE: begin
            if (dec_illegal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
               next_state = S_TRAP;
`else
               next_state = S_WB;
`endif
            end else begin
               next_state = S_EXEC;
            end
         end
         S_EXEC: begin
            case (dec_class)
               CLS_BRANCH: begin
                  br_op      = dec_br_op;
                  pc_write   = 1'b1;
                  if (dec_link) reg_write = RW_LINK;
                  next_state = run ? S_FETCH : S_IDLE;
               end
               CLS_LOAD, CLS_STORE: next_state = S_MEM;
               CLS_HALT:            next_state = S_HALT;
               default:             next_state = S_WB;
            endcase
         end
         S_MEM: begin
            dmem_enable = 1'b1;
            if (dec_class == CLS_STORE) begin
               dmem_write_enable = 1'b1;
               pc_write          = 1'b1;
               next_state        = run ? S_FETCH : S_IDLE;
            end else begin
               next_state = S_WB;
            end
         end
         S_WB: begin
            reg_write  = dec_illegal ? RW_NONE : RW_RS;
            pc_write   = 1'b1;
            next_state = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            next_state = S_HALT;
         end
         S_TRAP: begin
            next_state = S_TRAP;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Retired-instruction counter: one per PC update, holding at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retired <= '0;
      end else if (pc_write && (retired != {CNT_W{1'b1}})) begin
         retired <= retired + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. Each instruction is
// classified from the ISA rules and turned into an expected cycle-by-cycle
// outline (length, strobe cycle, memory cycle, write-back kind) that is
// compared against the DUT on every falling edge.
module tb_multicycle_control_unit;
   import kgp_ctrl_pkg::*;

   localparam int K_ALU  = 0;
   localparam int K_LD   = 1;
   localparam int K_ST   = 2;
   localparam int K_BR   = 3;
   localparam int K_HALT = 4;
   localparam int K_NOP  = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [5:0]  opcode;
   logic [5:0]  func;
   logic [1:0]  reg_write;
   logic        imm_mux_ctrl;
   logic        alu_mux_ctrl;
   logic [3:0]  alu_op;
   logic        dmem_enable;
   logic        dmem_write_enable;
   logic [1:0]  reg_write_mux_ctrl;
   logic [4:0]  br_op;
   logic        pc_write;
   logic        busy;
   logic        halted;
   logic [31:0] retired;

   int assert_count  = 0;
   int fail_count    = 0;
   int model_retired = 0;

   // Free-running clock.
   always #5 clk = ~clk;

   multicycle_control_unit #(.CNT_W(32)) dut (
      .clk                (clk),
      .rst                (rst),
      .run                (run),
      .opcode             (opcode),
      .func               (func),
      .reg_write          (reg_write),
      .imm_mux_ctrl       (imm_mux_ctrl),
      .alu_mux_ctrl       (alu_mux_ctrl),
      .alu_op             (alu_op),
      .dmem_enable        (dmem_enable),
      .dmem_write_enable  (dmem_write_enable),
      .reg_write_mux_ctrl (reg_write_mux_ctrl),
      .br_op              (br_op),
      .pc_write           (pc_write),
      .busy               (busy),
      .halted             (halted),
      .retired            (retired)
   );

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h t=%0t", tag, observed, expected, $time);
      end
   endtask

   // All control outputs quiet, not busy, not halted, counter matches model.
   task automatic check_idle(input string tag);
      check_output({tag, ".busy"}, 32'(busy), 32'd0);
      check_output({tag, ".halted"}, 32'(halted), 32'd0);
      check_output({tag, ".pc_write"}, 32'(pc_write), 32'd0);
      check_output({tag, ".reg_write"}, 32'(reg_write), 32'd0);
      check_output({tag, ".dmem_en"}, 32'(dmem_enable), 32'd0);
      check_output({tag, ".dmem_we"}, 32'(dmem_write_enable), 32'd0);
      check_output({tag, ".br_op"}, 32'(br_op), 32'd0);
      check_output({tag, ".alu_op"}, 32'(alu_op), 32'd0);
      check_output({tag, ".wb_mux"}, 32'(reg_write_mux_ctrl), 32'd0);
      check_output({tag, ".retired"}, retired, 32'(model_retired));
   endtask

   // Present one instruction starting at a falling edge whose following
   // rising edge enters FETCH; returns at the falling edge of its last cycle.
   task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] fn,
                                 input bit drop_run);
      int kind;
      int len;
      int e_pc, e_rw, e_den, e_dwe, e_br, e_alu, e_amux, e_imux, e_wb;
      opcode = op;
      func   = fn;
      if ((op == OP_ALU || op == OP_ALUI) && fn < 6'd9)      kind = K_ALU;
      else if (op == OP_LW)                                  kind = K_LD;
      else if (op == OP_SW)                                  kind = K_ST;
      else if ((op == OP_BR || op == OP_BRREG) && fn < 6'd4) kind = K_BR;
      else if (op == OP_HALT)                                kind = K_HALT;
      else                                                   kind = K_NOP;
      case (kind)
         K_LD:         len = 5;
         K_ALU, K_ST:  len = 4;
         default:      len = 3;
      endcase
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         e_pc  = (k == len && kind != K_HALT) ? 1 : 0;
         e_rw  = 0;
         if (k == len && (kind == K_ALU || kind == K_LD)) e_rw = 1;
         if (k == len && kind == K_BR && op == OP_BR && fn == 6'd1) e_rw = 2;
         e_den = ((kind == K_LD || kind == K_ST) && k == 4) ? 1 : 0;
         e_dwe = (kind == K_ST && k == 4) ? 1 : 0;
         e_br  = (kind == K_BR && k == 3) ? ((op == OP_BR) ? 1 : 5) + int'(fn) : 0;
         e_alu = (kind == K_ALU && k >= 3) ? int'(fn) : 0;
         e_amux = (k >= 3 && ((kind == K_ALU && op == OP_ALUI) || kind == K_LD || kind == K_ST)) ? 1 : 0;
         e_imux = (k >= 3 && (kind == K_LD || kind == K_ST)) ? 1 : 0;
         e_wb  = 0;
         if (k >= 3 && kind == K_ALU) e_wb = 2;
         if (k >= 3 && kind == K_LD)  e_wb = 1;
         check_output("pc_write", 32'(pc_write), e_pc);
         check_output("reg_write", 32'(reg_write), e_rw);
         check_output("dmem_en", 32'(dmem_enable), e_den);
         check_output("dmem_we", 32'(dmem_write_enable), e_dwe);
         check_output("br_op", 32'(br_op), e_br);
         check_output("alu_op", 32'(alu_op), e_alu);
         check_output("alu_mux", 32'(alu_mux_ctrl), e_amux);
         check_output("imm_mux", 32'(imm_mux_ctrl), e_imux);
         check_output("wb_mux", 32'(reg_write_mux_ctrl), e_wb);
         check_output("busy", 32'(busy), 32'd1);
         check_output("halted", 32'(halted), 32'd0);
         check_output("retired", retired, 32'(model_retired));
         if (drop_run && k == 2) run = 1'b0;
      end
      if (kind != K_HALT) model_retired++;
   endtask

   initial begin
      logic [5:0] r_op;
      logic [5:0] r_fn;
      int         pick;

      // Reset held for 10 cycles with run low.
      rst    = 1'b0;
      run    = 1'b0;
      opcode = OP_ALU;
      func   = 6'd0;
      repeat (10) @(negedge clk);
      check_idle("reset");
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("idle_run0");

      // Directed instructions: add, lw, sw, bl.
      $display("[TB] directed sequence");
      run = 1'b1;
      apply_stimulus(OP_ALU, 6'd0, 1'b0);
      apply_stimulus(OP_LW, 6'd0, 1'b0);
      apply_stimulus(OP_SW, 6'd0, 1'b0);
      apply_stimulus(OP_BR, 6'd1, 1'b0);
      apply_stimulus(OP_BRREG, 6'd3, 1'b0);

      // Randomized instruction stream.
      $display("[TB] random sequence");
      for (int n = 0; n < 60; n++) begin
         pick = int'($urandom_range(0, 9));
         r_fn = 6'($urandom_range(0, 63));
         case (pick)
            0, 1: begin r_op = OP_ALU;   r_fn = 6'($urandom_range(0, 8)); end
            2:    begin r_op = OP_ALUI;  r_fn = 6'($urandom_range(0, 8)); end
            3:    r_op = OP_LW;
            4:    r_op = OP_SW;
            5:    begin r_op = OP_BR;    r_fn = 6'($urandom_range(0, 3)); end
            6:    begin r_op = OP_BRREG; r_fn = 6'($urandom_range(0, 3)); end
`ifdef CTRL_ILLEGAL_TRAP_EN
            7, 8: begin r_op = OP_ALU;   r_fn = 6'($urandom_range(0, 8)); end
`else
            7:    r_op = 6'($urandom_range(7, 62));
            8:    begin r_op = OP_ALU;   r_fn = 6'($urandom_range(9, 63)); end
`endif
            default: begin r_op = OP_BR; r_fn = 6'd1; end
         endcase
         apply_stimulus(r_op, r_fn, 1'b0);
      end

      // run dropped mid-instruction: instruction completes, then IDLE.
      apply_stimulus(OP_ALU, 6'd1, 1'b1);
      @(negedge clk);
      check_idle("run_drop");
      run = 1'b1;

      // Reset asserted in the middle of a store: no strobes, counter cleared.
      opcode = OP_SW;
      func   = 6'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      model_retired = 0;
      #1;
      check_idle("mid_reset");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_idle("post_reset");
      run = 1'b1;

      // Unknown opcode 6'h2A.
`ifdef CTRL_ILLEGAL_TRAP_EN
      opcode = 6'h2A;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check_output("trap.halted", 32'(halted), 32'd1);
         check_output("trap.busy", 32'(busy), 32'd1);
         check_output("trap.pc_write", 32'(pc_write), 32'd0);
         check_output("trap.retired", retired, 32'(model_retired));
         @(negedge clk);
      end
      rst = 1'b0;
      run = 1'b0;
      model_retired = 0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      run = 1'b1;
`else
      apply_stimulus(6'h2A, 6'd0, 1'b0);
      apply_stimulus(OP_ALUI, 6'd2, 1'b0);
`endif

      // HALT: stays halted with run high, no further PC updates.
      apply_stimulus(OP_HALT, 6'd0, 1'b0);
      opcode = OP_ALU;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_output("halt.halted", 32'(halted), 32'd1);
         check_output("halt.busy", 32'(busy), 32'd0);
         check_output("halt.pc_write", 32'(pc_write), 32'd0);
         check_output("halt.retired", retired, 32'(model_retired));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
